la_ioanalog_seq: RTL
====================

# la_ioanalog_seq

Core-side sequencer for the three analog pad channels `aio[2:0]`. On request it routes one channel through core analog switches with break-before-make dead time and a programmable settle delay. It then strobes an external comparator and returns a majority-filtered 1-bit result. It sits between digital control logic and the analog pad's core interface, and owns every switch enable that touches `aio`.

## Interface
- N, 3, number of analog channels; `sel` width is SELW = clog2(N), so 2 when N = 3
- CNTW, 8, width of the dead-time and settle counters and their config inputs

Ports:
- clk  input  1  core clock
- nreset  input  1  reset, asynchronous, active-low
- req  input  1  conversion request; accepted on a rising edge of clk when `req & ~busy`
- sel  input  SELW  channel index, sampled when `req` is accepted
- off  input  1  disconnect all channels; honoured only in IDLE
- dead_cycles  input  CNTW  break time; a value of 0 is treated as 1
- settle_cycles  input  CNTW  settle time after the switch closes; 0 skips SETTLE
- cmp  input  1  asynchronous comparator output, synchronised with 2 flops internally
- en  output  N  one-hot analog switch enables; at most one bit high
- sample  output  1  comparator strobe
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle completion pulse
- result  output  1  majority result; held until the next successful `done`
- err  output  1  valid with `done`; high when `sel >= N`

## Operation
- Reset values: `en`=0, `sample`=0, `busy`=0, `done`=0, `result`=0, `err`=0, state IDLE, connected channel = NONE.
- Reset mid-operation: all outputs go to their reset values asynchronously; `en` opens immediately.
- States: IDLE, BREAK, SETTLE, SAMPLE, DONE.
- IDLE, request accepted:
  - if `sel >= N`, go to DONE with `err`=1; `en` and `result` are unchanged;
  - otherwise, if `sel` equals the connected channel, go straight to SAMPLE;
  - otherwise go to BREAK.
- BREAK: `en`=0 for D = max(`dead_cycles`,1) cycles.
- SETTLE: `en`=onehot(`sel`) for S = `settle_cycles` cycles. Connected channel := `sel` on entry. When S = 0, BREAK goes directly to SAMPLE with `en` asserted on SAMPLE entry.
- SAMPLE: lasts exactly 5 cycles with `sample`=1 throughout. The synchronised `cmp` is captured in SAMPLE cycles 3, 4 and 5. `result` := majority of the three captured bits, updated on entry to DONE.
- DONE: one cycle with `done`=1 and `err` valid, then return to IDLE. `busy` clears on the following cycle.
- `en` stays closed after DONE; the channel remains connected until the next request for a different channel or until `off`.
- `off` in IDLE: `en`=0 on the next edge, connected channel := NONE. `off` and `req` in the same IDLE cycle: `off` wins and `req` is dropped, not accepted.
- `req` while `busy` is ignored.
- `dead_cycles`, `settle_cycles` and `sel` are latched at acceptance. Later changes do not affect the operation in flight.
- Counters are CNTW bits wide. Maximum values are D = 2^CNTW-1 and S = 2^CNTW-1; no wrap occurs mid-phase.

## Timing
- Take the acceptance edge as cycle 0.
- New channel: BREAK occupies cycles 1..D, SETTLE D+1..D+S, SAMPLE D+S+1..D+S+5. `done`=1 in cycle D+S+6.
- Same channel: SAMPLE occupies cycles 1..5, `done` in cycle 6.
- Invalid `sel`: `done` and `err` in cycle 1.
- `busy` is high in cycles 1..done cycle. The earliest next acceptance is the edge at done cycle + 1.
- No cycle ever has two `en` bits high. The minimum gap between one bit falling and another rising is D ≥ 1 cycles.
- The `cmp` to `result` path is 2-flop synchronised. Bits captured in SAMPLE cycles 3, 4 and 5 reflect `cmp` from 2 cycles earlier.

## Test plan
- Reset behaviour: pulse `nreset` low while in SETTLE with `en`=3'b010 → `en`=0 asynchronously, before any clk edge. After release: state IDLE, `busy`=0, `result`=0, and a request for channel 1 goes through BREAK again.
- Basic conversion: `sel`=2, `dead_cycles`=3, `settle_cycles`=4, `cmp`=1 held → `en`=0 in cycles 1–3, `en`=3'b100 from cycle 4, `sample`=1 in cycles 8–12, `done`=1 and `result`=1 in cycle 13, `err`=0.
- Channel switch and same-channel repeat:
  - after connecting ch0, request ch1 with `dead_cycles`=0 → exactly 1 cycle with `en`=0 between 3'b001 and 3'b010;
  - then request ch1 again → no `en` change, `done` in cycle 6.
- Majority filter: synchronised `cmp` captures 1, 0, 1 → `result`=1; captures 0, 1, 0 → `result`=0.
- Invalid and ignored requests:
  - `sel`=3 → `done`=1, `err`=1 in cycle 1, with `en` and `result` unchanged;
  - a `req` pulse during `busy` → no second `done`.
- `off` handling: while ch2 is connected and idle, `off`=1 together with `req` → `en`=0 next cycle, `req` dropped, no `done`. A later `req` with `sel`=2 takes the BREAK path.

Source files
------------

// File: rtl/la_ioanalog_seq.sv
// Core-side sequencer for the analog pad channels: break-before-make switch
// routing, programmable settle delay, and a majority-filtered comparator read.
module la_ioanalog_seq #(
    parameter int N    = 3,
    parameter int CNTW = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            req,
    input  logic [SELW-1:0] sel,
    input  logic            off,
    input  logic [CNTW-1:0] dead_cycles,
    input  logic [CNTW-1:0] settle_cycles,
    input  logic            cmp,
    output logic [N-1:0]    en,
    output logic            sample,
    output logic            busy,
    output logic            done,
    output logic            result,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BREAK,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);
    localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'(4);

    state_t          state, state_next;
    logic [CNTW-1:0] cnt, cnt_next;
    logic [SELW-1:0] sel_q;
    logic [CNTW-1:0] settle_q;
    logic            conn_valid;
    logic [SELW-1:0] conn_idx;
    logic            cmp_meta, cmp_sync;
    logic [1:0]      cap;
    logic            err_q;

    logic accept, go_off, sel_bad, same_ch;
    logic conn_load, conn_clear;

    assign go_off  = (state == S_IDLE) && off;
    assign accept  = (state == S_IDLE) && req && !off;
    assign sel_bad = (int'(sel) >= N);
    assign same_ch = conn_valid && (conn_idx == sel);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        conn_load  = 1'b0;
        conn_clear = go_off;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (sel_bad) begin
                        state_next = S_DONE;
                    end else if (same_ch) begin
                        state_next = S_SAMPLE;
                        cnt_next   = SAMPLE_LAST;
                    end else begin
                        state_next = S_BREAK;
                        conn_clear = 1'b1;
                        cnt_next   = (dead_cycles == '0) ? '0 : dead_cycles - CNT_ONE;
                    end
                end
            end
            S_BREAK: begin
                if (cnt == '0) begin
                    conn_load = 1'b1;
                    if (settle_q != '0) begin
                        state_next = S_SETTLE;
                        cnt_next   = settle_q - CNT_ONE;
                    end else begin
                        state_next = S_SAMPLE;
                        cnt_next   = SAMPLE_LAST;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_next = S_SAMPLE;
                    cnt_next   = SAMPLE_LAST;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sel_q      <= '0;
            settle_q   <= '0;
            conn_valid <= 1'b0;
            conn_idx   <= '0;
            cmp_meta   <= 1'b0;
            cmp_sync   <= 1'b0;
            cap        <= '0;
            err_q      <= 1'b0;
            result     <= 1'b0;
        end else begin
            cmp_meta <= cmp;
            cmp_sync <= cmp_meta;
            if (accept) begin
                sel_q    <= sel;
                settle_q <= settle_cycles;
                err_q    <= sel_bad;
            end
            if (conn_clear) begin
                conn_valid <= 1'b0;
            end else if (conn_load) begin
                conn_valid <= 1'b1;
                conn_idx   <= sel_q;
            end
            // Captures land in SAMPLE cycles 3 and 4; cycle 5 uses the live bit.
            if (state == S_SAMPLE && (cnt == CNTW'(2) || cnt == CNT_ONE))
                cap <= {cap[0], cmp_sync};
            if (state == S_SAMPLE && cnt == '0)
                result <= (cap[1] & cap[0]) | (cap[1] & cmp_sync) | (cap[0] & cmp_sync);
        end
    end

    assign en     = conn_valid ? (N'(1) << conn_idx) : '0;
    assign sample = (state == S_SAMPLE);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = done & err_q;

endmodule
